// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the execute-stage PC-write control: ARM condition
// codes, flag bit positions and the flush FSM state type.
package pc_branch_ctrl_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flush counter width; covers FLUSH_CYCLES up to 15
    localparam int FCNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pc_branch_ctrl_cond_check.sv
// Combinational ARM condition evaluator: condition field plus {N,Z,C,V}
// gives a single pass/fail bit.
module cond_check
    import pc_branch_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_ok
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_ok = 1'b1;
        case (i_cond)
            COND_EQ: o_ok = w_z;
            COND_NE: o_ok = ~w_z;
            COND_CS: o_ok = w_c;
            COND_CC: o_ok = ~w_c;
            COND_MI: o_ok = w_n;
            COND_PL: o_ok = ~w_n;
            COND_VS: o_ok = w_v;
            COND_VC: o_ok = ~w_v;
            COND_HI: o_ok = w_c & ~w_z;
            COND_LS: o_ok = ~w_c | w_z;
            COND_GE: o_ok = (w_n == w_v);
            COND_LT: o_ok = (w_n != w_v);
            COND_GT: o_ok = ~w_z & (w_n == w_v);
            COND_LE: o_ok = w_z | (w_n != w_v);
            // AL and the 4'b1111 encoding both always execute
            default: o_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Execute-stage PC-write control: qualifies register/memory/PC writes with
// condition codes, squashes wrong-path slots after a redirect, counts redirects.
module pc_branch_ctrl
    import pc_branch_ctrl_pkg::*;
#(
    parameter int RD_W         = 4,
    parameter int PC_REG       = 15,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [RD_W-1:0]  rd,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             branch,
    input  logic [1:0]       flag_w,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    output logic             pcs,
    output logic             pc_src,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic [3:0]       flags_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
    localparam bit                FLUSH_EN   = (FLUSH_CYCLES != 0);

    state_t            r_state;
    state_t            w_state_next;
    logic [FCNT_W-1:0] r_flush_cnt;
    logic [FCNT_W-1:0] w_flush_cnt_next;
    logic [3:0]        r_flags;
    logic [CNT_W-1:0]  r_taken;

    logic w_pcs;
    logic w_cond_ok;
    logic w_exec;
    logic w_pc_src;
    logic w_advance;

    cond_check u_cond_check (
        .i_cond  (cond),
        .i_flags (r_flags),
        .o_ok    (w_cond_ok)
    );

    assign w_pcs     = valid_i & (((rd == RD_W'(PC_REG)) & reg_w) | branch);
    assign w_exec    = valid_i & w_cond_ok & (r_state == ST_IDLE);
    assign w_pc_src  = w_exec & w_pcs;
    assign w_advance = ~stall_i;

    assign pcs         = w_pcs;
    assign pc_src      = w_pc_src;
    assign reg_write_o = w_exec & reg_w;
    assign mem_write_o = w_exec & mem_w;
    assign flags_o     = r_flags;
    assign flush_o     = (r_state == ST_FLUSH);
    assign taken_cnt   = r_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_advance) begin
            if (flag_w[1]) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[0]) begin
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else if (w_advance) begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pc_src && FLUSH_EN) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                // The last squashed slot leaves on the edge where one remains
                if (r_flush_cnt == FCNT_W'(1)) begin
                    w_state_next     = ST_IDLE;
                    w_flush_cnt_next = '0;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - FCNT_W'(1);
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_flush_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken <= '0;
        end else if (w_pc_src && w_advance && (r_taken != {CNT_W{1'b1}})) begin
            r_taken <= r_taken + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model; a second narrow-counter, no-flush instance.
module tb_pc_branch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_i, stall_i, reg_w, mem_w, branch;
    logic [3:0]  rd, cond, alu_flags;
    logic [1:0]  flag_w;
    logic        pcs, pc_src, reg_write_o, mem_write_o, flush_o;
    logic [3:0]  flags_o;
    logic [15:0] taken_cnt;

    logic        s_reset, s_valid, s_stall, s_reg_w, s_mem_w, s_branch;
    logic [3:0]  s_rd, s_cond, s_alu_flags;
    logic [1:0]  s_flag_w;
    logic        s_pcs, s_pc_src, s_reg_write, s_mem_write, s_flush;
    logic [3:0]  s_flags;
    logic [1:0]  s_taken;

    pc_branch_ctrl #(.RD_W(4), .PC_REG(15), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .rd(rd),
        .reg_w(reg_w), .mem_w(mem_w), .branch(branch), .flag_w(flag_w), .cond(cond),
        .alu_flags(alu_flags), .pcs(pcs), .pc_src(pc_src), .reg_write_o(reg_write_o),
        .mem_write_o(mem_write_o), .flags_o(flags_o), .flush_o(flush_o), .taken_cnt(taken_cnt)
    );

    pc_branch_ctrl #(.RD_W(4), .PC_REG(15), .FLUSH_CYCLES(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(s_reset), .valid_i(s_valid), .stall_i(s_stall), .rd(s_rd),
        .reg_w(s_reg_w), .mem_w(s_mem_w), .branch(s_branch), .flag_w(s_flag_w), .cond(s_cond),
        .alu_flags(s_alu_flags), .pcs(s_pcs), .pc_src(s_pc_src), .reg_write_o(s_reg_write),
        .mem_write_o(s_mem_write), .flags_o(s_flags), .flush_o(s_flush), .taken_cnt(s_taken)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    // Behavioural model state
    logic [3:0] m_flags;
    int         m_left;
    int         m_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Check the current cycle against the model, clock it, advance the model.
    task automatic cycle();
        bit m_pcs, m_exec, m_pc;
        #1;
        m_pcs  = valid_i && ((rd == 4'd15 && reg_w) || branch);
        m_exec = valid_i && ref_cond(cond, m_flags) && (m_left == 0);
        m_pc   = m_exec && m_pcs;
        check("pcs", 32'(pcs), 32'(m_pcs));
        check("pc_src", 32'(pc_src), 32'(m_pc));
        check("reg_write", 32'(reg_write_o), 32'(m_exec && reg_w));
        check("mem_write", 32'(mem_write_o), 32'(m_exec && mem_w));
        check("flags", 32'(flags_o), 32'(m_flags));
        check("flush", 32'(flush_o), 32'(m_left > 0));
        check("taken", 32'(taken_cnt), 32'(m_taken));
        $display("cyc %0d rst=%0b v=%0b st=%0b cond=%0h rd=%0d rw=%0b br=%0b pc_src=%0b flush=%0b taken=%0d",
                 n_cyc, reset, valid_i, stall_i, cond, rd, reg_w, branch, pc_src, flush_o, taken_cnt);
        @(posedge clk);
        n_cyc++;
        if (reset) begin
            m_flags = 4'b0; m_left = 0; m_taken = 0;
        end else if (!stall_i) begin
            if (m_exec) begin
                if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
                if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
            end
            if (m_pc && m_taken < 65535) m_taken++;
            if (m_left > 0) m_left--;
            else if (m_pc) m_left = 2;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; valid_i = 0; stall_i = 0; reg_w = 0; mem_w = 0; branch = 0;
        rd = 0; cond = 4'hE; alu_flags = 0; flag_w = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    initial begin
        int cnt;
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        m_flags = 4'b0; m_left = 0; m_taken = 0;
        check("reset_flags", 32'(flags_o), 32'h0);
        check("reset_flush", 32'(flush_o), 32'h0);
        check("reset_taken", 32'(taken_cnt), 32'h0);
        reset = 0;

        // 1: flag load, then EQ-qualified register write
        valid_i = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b0100;
        cycle();
        check("t1_flags", 32'(flags_o), 32'h4);
        flag_w = 0; alu_flags = 0; cond = 4'h0; reg_w = 1; rd = 4'd3;
        #1;
        check("t1_regw", 32'(reg_write_o), 32'h1);
        check("t1_pcsrc", 32'(pc_src), 32'h0);
        cycle();

        // 2: EQ branch fails with Z clear
        do_reset();
        valid_i = 1; cond = 4'h0; branch = 1;
        #1;
        check("t2_pcsrc", 32'(pc_src), 32'h0);
        cycle();
        check("t2_flush", 32'(flush_o), 32'h0);
        check("t2_taken", 32'(taken_cnt), 32'h0);

        // 3: write to PC redirects, then two squashed slots
        idle_inputs();
        valid_i = 1; cond = 4'hE; reg_w = 1; rd = 4'd15;
        #1;
        check("t3_pcs", 32'(pcs), 32'h1);
        check("t3_pcsrc", 32'(pc_src), 32'h1);
        cycle();
        mem_w = 1; rd = 4'd2;
        cnt = 0;
        while (flush_o && cnt < 20) begin
            #1;
            check("t3_regw_sq", 32'(reg_write_o), 32'h0);
            check("t3_memw_sq", 32'(mem_write_o), 32'h0);
            cycle();
            cnt++;
        end
        check("t3_flush_len", 32'(cnt), 32'd2);

        // 4: redirect then a 3-cycle stall inside FLUSH
        idle_inputs();
        valid_i = 1; branch = 1;
        cycle();
        branch = 0;
        cnt = 0;
        while (flush_o && cnt < 20) begin
            stall_i = (cnt >= 1 && cnt <= 3);
            cycle();
            cnt++;
        end
        stall_i = 0;
        check("t4_flush_len", 32'(cnt), 32'd5);

        // 5: reset (with stall) while flushing
        idle_inputs();
        valid_i = 1; branch = 1; flag_w = 2'b11; alu_flags = 4'hF;
        cycle();
        check("t5_in_flush", 32'(flush_o), 32'h1);
        idle_inputs();
        reset = 1; stall_i = 1;
        cycle();
        check("t5_flush", 32'(flush_o), 32'h0);
        check("t5_flags", 32'(flags_o), 32'h0);
        check("t5_taken", 32'(taken_cnt), 32'h0);
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            valid_i   = ($urandom_range(0, 9) < 8);
            stall_i   = ($urandom_range(0, 3) == 0);
            rd        = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            reg_w     = 1'($urandom);
            mem_w     = 1'($urandom);
            branch    = ($urandom_range(0, 4) == 0);
            flag_w    = 2'($urandom);
            cond      = 4'($urandom);
            alu_flags = 4'($urandom);
            cycle();
        end
        idle_inputs();
    end

    // 6: narrow saturating counter without flush, then full cond_ok sweep
    initial begin
        s_reset = 1; s_valid = 0; s_stall = 0; s_reg_w = 0; s_mem_w = 0; s_branch = 0;
        s_rd = 0; s_cond = 4'hE; s_alu_flags = 0; s_flag_w = 0;
        @(posedge clk);
        #1;
        s_reset = 0;
        for (int k = 1; k <= 5; k++) begin
            s_valid = 1; s_branch = 1; s_cond = 4'hE;
            @(posedge clk);
            #1;
            check("sat_taken", 32'(s_taken), 32'((k < 3) ? k : 3));
            check("sat_noflush", 32'(s_flush), 32'h0);
            $display("sat branch %0d taken_cnt=%0d", k, s_taken);
        end
        for (int f = 0; f < 16; f++) begin
            s_branch = 0; s_cond = 4'hE; s_flag_w = 2'b11; s_alu_flags = 4'(f);
            @(posedge clk);
            #1;
            s_flag_w = 0;
            check("sweep_flags", 32'(s_flags), 32'(f));
            for (int c = 0; c < 16; c++) begin
                s_cond = 4'(c); s_branch = 1;
                #1;
                check("sweep_cond", 32'(s_pc_src), 32'(ref_cond(4'(c), 4'(f))));
            end
            s_branch = 0;
            $display("sweep flags=%0h done", f);
        end
        s_valid = 0;
    end

    initial begin
        #60000;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
